// File: rtl/lv_wdg_pkg.sv
// lv_wdg_pkg: scanner FSM states and the bit-serial CRC-8 step (poly 0x07, init 0x00, MSB first)
package lv_wdg_pkg;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;
  typedef enum logic [1:0] {IDLE, REQ, CHK} scan_state_t;
  function automatic logic [7:0] crc8_bit(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? CRC8_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/lv_crc8_calc.sv
// lv_crc8_calc: combinational CRC-8 of data[DW-1:0] (MSB first) -> crc[7:0]
module lv_crc8_calc
  import lv_wdg_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] data,
  output logic [7:0]    crc
);
  always_comb begin
    crc = CRC8_INIT;
    for (int i = DW - 1; i >= 0; i--) crc = crc8_bit(crc, data[i]);
  end
endmodule

// File: rtl/lv_wdg_scan_ctrl.sv
// lv_wdg_scan_ctrl: periodic register CRC scanner (rd_req/addr out, ack/data/crc in, err/done pulses) plus SPI-silence watchdog
module lv_wdg_scan_ctrl
  import lv_wdg_pkg::*;
#(
  parameter int                REG_AW          = 7,
  parameter int                REG_DW          = 8,
  parameter int                REG_CRC_W       = 8,
  parameter logic [REG_AW-1:0] SCAN_START_ADDR = 7'h00,
  parameter logic [REG_AW-1:0] SCAN_END_ADDR   = 7'h3F,
  parameter int                SCAN_PERIOD     = 1024,
  parameter int                ACK_TO          = 64,
  parameter int                WDG_TO          = 65535
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_scan_en,
  output logic                 o_wdg_scan_reg_rd_req,
  output logic [REG_AW-1:0]    o_wdg_scan_reg_addr,
  input  logic                 i_reg_wdg_scan_ack,
  input  logic [REG_DW-1:0]    i_reg_wdg_scan_data,
  input  logic [REG_CRC_W-1:0] i_reg_wdg_scan_crc,
  input  logic                 i_spi_rst_wdg,
  input  logic                 i_wdg_clr,
  output logic                 o_crc_err,
  output logic [REG_AW-1:0]    o_err_addr,
  output logic [7:0]           o_err_cnt,
  output logic                 o_ack_to,
  output logic                 o_scan_done,
  output logic                 o_wdg_expire
);
  localparam int PW = $clog2(SCAN_PERIOD);
  localparam int AW = $clog2(ACK_TO + 1);
  localparam int WW = $clog2(WDG_TO + 1);
  localparam logic [PW-1:0] RELOAD = PW'(SCAN_PERIOD - 1);
  scan_state_t          state;
  logic [PW-1:0]        per_cnt;
  logic [AW-1:0]        ack_cnt;
  logic [WW-1:0]        wdg_cnt;
  logic [REG_DW-1:0]    data_q;
  logic [REG_CRC_W-1:0] crc_q;
  logic [7:0]           crc_calc;
  logic                 to_hit, adv, mis, last;
  lv_crc8_calc #(.DW(REG_DW)) u_crc (.data(data_q), .crc(crc_calc));
  assign to_hit = state == REQ && !i_reg_wdg_scan_ack && ack_cnt == AW'(ACK_TO - 1);
  assign adv    = i_scan_en && (state == CHK || to_hit);
  assign mis    = i_scan_en && state == CHK && crc_q != REG_CRC_W'(crc_calc);
  assign last   = o_wdg_scan_reg_addr == SCAN_END_ADDR;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                 <= IDLE;
      per_cnt               <= RELOAD;
      ack_cnt               <= '0;
      data_q                <= '0;
      crc_q                 <= '0;
      o_wdg_scan_reg_rd_req <= 1'b0;
      o_wdg_scan_reg_addr   <= SCAN_START_ADDR;
      o_crc_err             <= 1'b0;
      o_err_addr            <= '0;
      o_ack_to              <= 1'b0;
      o_scan_done           <= 1'b0;
    end else begin
      o_crc_err   <= 1'b0;
      o_ack_to    <= 1'b0;
      o_scan_done <= 1'b0;
      if (!i_scan_en) begin
        state                 <= IDLE;
        o_wdg_scan_reg_rd_req <= 1'b0;
        per_cnt               <= RELOAD;
      end else begin
        case (state)
          IDLE:
            if (per_cnt == '0) begin
              o_wdg_scan_reg_addr   <= SCAN_START_ADDR;
              ack_cnt               <= '0;
              o_wdg_scan_reg_rd_req <= 1'b1;
              state                 <= REQ;
            end else begin
              per_cnt <= per_cnt - 1'b1;
            end
          REQ:
            if (i_reg_wdg_scan_ack) begin
              data_q                <= i_reg_wdg_scan_data;
              crc_q                 <= i_reg_wdg_scan_crc;
              o_wdg_scan_reg_rd_req <= 1'b0;
              state                 <= CHK;
            end else begin
              ack_cnt  <= ack_cnt + 1'b1;
              o_ack_to <= to_hit;
            end
          CHK: begin
            o_crc_err <= mis;
            if (mis) o_err_addr <= o_wdg_scan_reg_addr;
          end
          default: state <= IDLE;
        endcase
        if (adv) begin
          if (last) begin
            o_scan_done           <= 1'b1;
            per_cnt               <= RELOAD;
            o_wdg_scan_reg_rd_req <= 1'b0;
            state                 <= IDLE;
          end else begin
            o_wdg_scan_reg_addr   <= o_wdg_scan_reg_addr + 1'b1;
            ack_cnt               <= '0;
            o_wdg_scan_reg_rd_req <= 1'b1;
            state                 <= REQ;
          end
        end
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err_cnt    <= 8'd0;
      wdg_cnt      <= '0;
      o_wdg_expire <= 1'b0;
    end else begin
      if (mis) o_err_cnt <= i_wdg_clr ? 8'd1 : (o_err_cnt == 8'hFF ? o_err_cnt : o_err_cnt + 8'd1);
      else if (i_wdg_clr) o_err_cnt <= 8'd0;
      if (i_spi_rst_wdg) begin
        wdg_cnt      <= '0;
        o_wdg_expire <= 1'b0;
      end else begin
        if (wdg_cnt != WW'(WDG_TO)) wdg_cnt <= wdg_cnt + 1'b1;
        o_wdg_expire <= (wdg_cnt == WW'(WDG_TO - 1)) | (o_wdg_expire & ~i_wdg_clr);
      end
    end
  end
endmodule
